// File: rtl/decode_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : decode_rr_arbiter
// Brief   : Four-requester round-robin arbiter driving a 2-to-4 decoder
//           select, with hold-limit preemption and a dead cycle per handover.
// Revision: 1.0 - initial release
// ============================================================================
module decode_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       preempt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] c_hold_max  = '1;

    state_t            r_state;
    logic [1:0]        r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;

    logic [2:0] w_arb;
    logic       w_found;
    logic [1:0] w_winner;
    logic       w_owner_req;
    logic       w_others;
    logic       w_hold_hit;

    // Scan from lowest to highest priority so the last hit is the winner.
    function automatic logic [2:0] f_arb(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, p};
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_arb       = f_arb(req, r_ptr);
    assign w_found     = w_arb[2];
    assign w_winner    = w_arb[1:0];
    assign w_owner_req = req[grant_idx];
    assign w_others    = |(req & ~grant);
    assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last) && w_others;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= '0;
            grant       <= 4'b0000;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RELEASE: begin
                    if (w_found) begin
                        r_state     <= ST_GRANT;
                        grant_idx   <= w_winner;
                        grant       <= 4'b0001 << w_winner;
                        grant_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_req || w_hold_hit) begin
                        r_state     <= ST_RELEASE;
                        grant       <= 4'b0000;
                        grant_valid <= 1'b0;
                        r_ptr       <= grant_idx + 2'd1;
                        r_hold_cnt  <= '0;
                        // Still requesting here means the hold limit forced the exit.
                        preempt     <= w_owner_req;
                    end else if (r_hold_cnt != c_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
